// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the 8-digit seven-segment scan driver: shadow-load inputs
// and the registered display/scan outputs.
`timescale 1ns/1ps
interface seg7_scan_driver_if;
  logic        load;
  logic [31:0] digits;
  logic [7:0]  digit_on;
  logic [7:0]  dp;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;
  logic [2:0]  scan_idx;
  logic        frame_done;

  modport master (
    output load, digits, digit_on, dp,
    input  an, dec_ddp, scan_idx, frame_done
  );

  modport slave (
    input  load, digits, digit_on, dp,
    output an, dec_ddp, scan_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver (active-low anodes and
// segments), one digit per REFRESH_DIV-cycle slot, fully registered outputs.
`timescale 1ns/1ps
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_W       = 17
) (
  input logic           clock,
  input logic           reset,
  seg7_scan_driver_if.slave bus
);

  logic [31:0]      sh_digits;
  logic [7:0]       sh_on;
  logic [7:0]       sh_dp;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx_q;
  logic             wrap7_q;
  logic             frame_done_q;
  logic [7:0]       an_q;
  logic [7:0]       dec_q;
  logic             slot_end;
  logic [3:0]       cur_digit;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_end  = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign cur_digit = sh_digits[{scan_idx_q, 2'b00} +: 4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_digits <= '0;
      sh_on     <= '0;
      sh_dp     <= '0;
    end else if (bus.load) begin
      sh_digits <= bus.digits;
      sh_on     <= bus.digit_on;
      sh_dp     <= bus.dp;
    end
  end

  // wrap7_q marks the 7->0 edge; frame_done follows it one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      scan_idx_q   <= '0;
      wrap7_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wrap7_q      <= slot_end && (scan_idx_q == 3'd7);
      frame_done_q <= wrap7_q;
      if (slot_end) begin
        div_cnt    <= '0;
        scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
        div_cnt    <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      dec_q <= '1;
    end else if (sh_on[scan_idx_q]) begin
      an_q  <= ~(8'b1 << scan_idx_q);
      dec_q <= {seg(cur_digit), ~sh_dp[scan_idx_q]};
    end else begin
      an_q  <= '1;
      dec_q <= '1;
    end
  end

  assign bus.an         = an_q;
  assign bus.dec_ddp    = dec_q;
  assign bus.scan_idx   = scan_idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model pushes
// expected outputs each edge, a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_seg7_scan_driver;
  localparam int unsigned R = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_DIV(R), .DIV_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] an;
    logic [7:0] ddp;
    logic [2:0] idx;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  logic [6:0] segtab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan is derived purely from the number
  // of edges seen since reset released.
  initial begin
    int unsigned n;
    logic [3:0]  m_dig [8];
    logic [7:0]  m_on, m_dp;
    logic [2:0]  cur;
    exp_t        e;
    n = 0; m_on = '0; m_dp = '0;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        n = 0; m_on = '0; m_dp = '0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        e.an = 8'hFF; e.ddp = 8'hFF; e.idx = 3'd0; e.fd = 1'b0;
      end else begin
        cur = 3'((n / R) % 8);
        if (m_on[cur]) begin
          e.an  = ~(8'b1 << cur);
          e.ddp = {segtab[m_dig[cur]], ~m_dp[cur]};
        end else begin
          e.an  = 8'hFF;
          e.ddp = 8'hFF;
        end
        if (bus.load) begin
          for (int i = 0; i < 8; i++) m_dig[i] = bus.digits[4*i +: 4];
          m_on = bus.digit_on;
          m_dp = bus.dp;
        end
        n++;
        e.idx = 3'((n / R) % 8);
        e.fd  = (n > 8*R) && (((n - 1) % (8*R)) == 0);
      end
      sbq.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL queue_empty: got 0 entries expected >=1 at %0t", $time);
      end else begin
        e = sbq.pop_front();
        if (reset) begin
          e.an = 8'hFF; e.ddp = 8'hFF; e.idx = 3'd0; e.fd = 1'b0;
        end
        chk("an",         bus.an,                e.an);
        chk("dec_ddp",    bus.dec_ddp,           e.ddp);
        chk("scan_idx",   {5'd0, bus.scan_idx},  {5'd0, e.idx});
        chk("frame_done", {7'd0, bus.frame_done}, {7'd0, e.fd});
      end
    end
  end

  task automatic idle(input int unsigned k);
    repeat (k) @(negedge clock);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] on, input logic [7:0] p);
    bus.load = 1'b1; bus.digits = d; bus.digit_on = on; bus.dp = p;
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  initial begin
    int unsigned k;
    bus.load = 1'b0; bus.digits = '0; bus.digit_on = '0; bus.dp = '0;
    #30 reset = 1'b0;
    idle(20);
    do_load(32'h76543210, 8'hFF, 8'h00);
    idle(80);
    do_load(32'h76543210, 8'h0F, 8'h00);
    idle(70);
    do_load(32'h76543218, 8'hFF, 8'h01);
    idle(40);
    do_load(32'h7654321F, 8'hFF, 8'h00);
    idle(20);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.load = 1'b1; bus.digits = $urandom;
        bus.digit_on = 8'($urandom); bus.dp = 8'($urandom);
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clock);
    end
    bus.load = 1'b0;
    do_load($urandom, 8'hFF, 8'($urandom));
    idle(2);
    for (k = 0; k < 100 && bus.scan_idx != 3'd5; k++) @(negedge clock);
    ncmp++;
    if (k >= 100) begin
      nerr++;
      $display("FAIL wait_scan5: got %0d cycles expected <100", k);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_an",       bus.an,      8'hFF);
    chk("async_dec_ddp",  bus.dec_ddp, 8'hFF);
    chk("async_scan_idx", {5'd0, bus.scan_idx}, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(40);
    do_load($urandom, 8'($urandom), 8'($urandom));
    idle(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
